// File: rtl/spi_burst_ram_wrapper.sv
// SPI-style serial front end to a single-port RAM.
// Each frame carries a 2-bit command and then a DATA_W-bit payload, both MSB first.
// Write-data and read-data frames can continue as bursts while SS_n stays low.
module spi_burst_ram_wrapper #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int BURST_EN = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic busy
);

  localparam int MEM_DEPTH = 2 ** ADDR_W;
  localparam int CNT_W     = $clog2(DATA_W + 2);

  localparam logic [CNT_W-1:0]  CMD_LAST  = CNT_W'(DATA_W + 1);
  localparam logic [CNT_W-1:0]  WORD_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  typedef enum logic [2:0] {IDLE, RX_CMD, WRITE, READ_ADD, READ_DATA} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W:0]     sr_q, sr_d;      // MOSI shift register: command bits and payload
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;
  logic [DATA_W-1:0]   sh_q, sh_d;      // MISO shift register
  logic                drop_q, drop_d;  // WRITE state ignores MOSI until SS_n goes high
  logic                done_q, done_d;  // single read word already sent (no burst)
  logic                miso_q, miso_d;

  logic [DATA_W-1:0]   mem [MEM_DEPTH];
  logic [DATA_W-1:0]   word_q;          // registered RAM read data
  logic                mem_we, mem_re;
  logic [DATA_W-1:0]   mem_wdata;
  logic [ADDR_W-1:0]   mem_raddr;

  logic [DATA_W+1:0]   full;
  logic [1:0]          cmd;
  logic [DATA_W-1:0]   payload;
  logic [DATA_W-1:0]   word_in;

  assign full    = {sr_q, MOSI};
  assign cmd     = full[DATA_W+1:DATA_W];
  assign payload = full[DATA_W-1:0];
  assign word_in = {sr_q[DATA_W-2:0], MOSI};

  // Next state, datapath updates and RAM strobes
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    waddr_d   = waddr_q;
    raddr_d   = raddr_q;
    sh_d      = sh_q;
    drop_d    = drop_q;
    done_d    = done_q;
    miso_d    = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_wdata = word_in;
    mem_raddr = raddr_q;

    if (state_q != IDLE && SS_n) begin
      // Frame aborted or finished: partial words are dropped
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!SS_n) begin
            state_d = RX_CMD;
            cnt_d   = '0;
            sr_d    = '0;
          end
        end
        RX_CMD: begin
          sr_d  = {sr_q[DATA_W-1:0], MOSI};
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CMD_LAST) begin
            cnt_d = '0;
            unique case (cmd)
              2'b00: begin
                waddr_d = payload[ADDR_W-1:0];
                state_d = WRITE;
                drop_d  = 1'b1;
              end
              2'b01: begin
                mem_we    = 1'b1;
                mem_wdata = payload;
                state_d   = WRITE;
                drop_d    = (BURST_EN == 0);
                if (BURST_EN != 0) waddr_d = waddr_q + ADDR_ONE;
              end
              2'b10: begin
                raddr_d = payload[ADDR_W-1:0];
                state_d = WRITE;
                drop_d  = 1'b1;
              end
              2'b11: begin
                mem_re  = 1'b1;
                state_d = READ_ADD;
              end
              default: state_d = IDLE;
            endcase
          end
        end
        WRITE: begin
          if (!drop_q) begin
            sr_d  = {sr_q[DATA_W-1:0], MOSI};
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == WORD_LAST) begin
              mem_we    = 1'b1;
              mem_wdata = word_in;
              waddr_d   = waddr_q + ADDR_ONE;
              cnt_d     = '0;
            end
          end
        end
        READ_ADD: begin
          // Extra stage so the first MSB leaves two edges after the command ends
          sh_d    = word_q;
          cnt_d   = '0;
          done_d  = 1'b0;
          state_d = READ_DATA;
        end
        READ_DATA: begin
          if (!done_q) begin
            miso_d = sh_q[DATA_W-1];
            sh_d   = {sh_q[DATA_W-2:0], 1'b0};
            cnt_d  = cnt_q + CNT_ONE;
            // Prefetch the next word early so it is ready when this one ends
            if (BURST_EN != 0 && cnt_q == '0) begin
              raddr_d   = raddr_q + ADDR_ONE;
              mem_re    = 1'b1;
              mem_raddr = raddr_q + ADDR_ONE;
            end
            if (cnt_q == WORD_LAST) begin
              cnt_d = '0;
              if (BURST_EN != 0) sh_d = word_q;
              else               done_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      waddr_q <= '0;
      raddr_q <= '0;
      sh_q    <= '0;
      drop_q  <= 1'b0;
      done_q  <= 1'b0;
      miso_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      waddr_q <= waddr_d;
      raddr_q <= raddr_d;
      sh_q    <= sh_d;
      drop_q  <= drop_d;
      done_q  <= done_d;
      miso_q  <= miso_d;
    end
  end

  // Single-port RAM; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[waddr_q] <= mem_wdata;
    if (mem_re) word_q <= mem[mem_raddr];
  end

  assign MISO = miso_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_spi_burst_ram_wrapper.sv
// Scoreboard bench for spi_burst_ram_wrapper: burst instance (0) and non-burst instance (1).
module tb_spi_burst_ram_wrapper;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] ss_n;
  logic [1:0] mosi;
  logic [1:0] miso;
  logic [1:0] busy;

  spi_burst_ram_wrapper #(.DATA_W(8), .ADDR_W(8), .BURST_EN(1)) u_dut_burst (
    .clk  (clk),
    .rst  (rst),
    .SS_n (ss_n[0]),
    .MOSI (mosi[0]),
    .MISO (miso[0]),
    .busy (busy[0])
  );

  spi_burst_ram_wrapper #(.DATA_W(8), .ADDR_W(8), .BURST_EN(0)) u_dut_single (
    .clk  (clk),
    .rst  (rst),
    .SS_n (ss_n[1]),
    .MOSI (mosi[1]),
    .MISO (miso[1]),
    .busy (busy[1])
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp;
  int n_bad;
  int sel;
  logic [7:0] mdl [2][256];

  typedef struct {
    int    cyc;
    int    dut;
    logic  val;
    string tag;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // MISO monitor: pops each expected bit on the cycle it is due
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        if (e.cyc < cyc) check({e.tag, "_late"}, e.cyc, cyc);
        else             check(e.tag, miso[e.dut], e.val);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic m);
    ss_n[sel] = s;
    mosi[sel] = m;
    step();
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, v[7-i]);
  endtask

  task automatic start_frame();
    drive(1'b0, 1'b0);
    check("busy_start", busy[sel], 1);
  endtask

  task automatic end_frame();
    drive(1'b1, 1'b0);
    check("busy_end", busy[sel], 0);
    check("miso_end", miso[sel], 0);
  endtask

  task automatic cmd_frame(input logic [1:0] c, input logic [7:0] p);
    start_frame();
    send_bits({c, 6'b0}, 2);
    send_bits(p, 8);
  endtask

  task automatic set_addr(input logic [1:0] c, input logic [7:0] a);
    cmd_frame(c, a);
    end_frame();
  endtask

  task automatic push(input int c, input logic v, input string t);
    sb.push_back('{c, sel, v, t});
  endtask

  task automatic push_word(input int c0, input logic [7:0] w, input string t);
    for (int i = 0; i < 8; i++) push(c0 + i, w[7-i], t);
  endtask

  // Read-data frame from the current read address, streaming nw words
  task automatic read_cur(input logic [7:0] a, input int nw, input string t);
    int e0;
    logic [7:0] aw;
    cmd_frame(2'b11, 8'h00);
    e0 = cyc;
    push(e0 + 1, 1'b0, {t, "_lead"});
    for (int w = 0; w < nw; w++) begin
      aw = a + 8'(w);
      push_word(e0 + 2 + 8 * w, mdl[sel][aw], t);
    end
    if (sel == 1) begin
      push(e0 + 10, 1'b0, {t, "_tail"});
      push(e0 + 11, 1'b0, {t, "_tail"});
    end
    for (int i = 0; i < 8 * nw + ((sel == 1) ? 3 : 1); i++) drive(1'b0, 1'b0);
    check("busy_stream", busy[sel], 1);
    end_frame();
  endtask

  task automatic read_words(input logic [7:0] a, input int nw, input string t);
    set_addr(2'b10, a);
    read_cur(a, nw, t);
  endtask

  initial begin
    int e0;
    logic [7:0] a1;
    rst  = 1'b1;
    ss_n = 2'b11;
    mosi = 2'b00;
    sel  = 0;
    repeat (3) step();
    check("rst_miso0", miso[0], 0);
    check("rst_busy0", busy[0], 0);
    check("rst_miso1", miso[1], 0);
    check("rst_busy1", busy[1], 0);
    rst = 1'b0;
    step();

    // Basic write then read back
    set_addr(2'b00, 8'h1F);
    cmd_frame(2'b01, 8'h55);
    end_frame();
    mdl[0][8'h1F] = 8'h55;
    read_words(8'h1F, 1, "r030");

    // Burst write across the top of memory
    set_addr(2'b00, 8'hFE);
    cmd_frame(2'b01, 8'hA1);
    send_bits(8'hA2, 8);
    send_bits(8'hA3, 8);
    end_frame();
    mdl[0][8'hFE] = 8'hA1;
    mdl[0][8'hFF] = 8'hA2;
    mdl[0][8'h00] = 8'hA3;
    read_words(8'hFE, 3, "r032");

    // Aborted write frame leaves data and write address alone
    set_addr(2'b00, 8'h1F);
    start_frame();
    send_bits(8'h40, 2);
    send_bits(8'hFF, 5);
    end_frame();
    read_words(8'h1F, 1, "r033_keep");
    cmd_frame(2'b01, 8'h66);
    end_frame();
    mdl[0][8'h1F] = 8'h66;
    read_words(8'h1F, 1, "r033_waddr");

    // Reset in the middle of a read stream
    set_addr(2'b10, 8'hFE);
    cmd_frame(2'b11, 8'h00);
    e0 = cyc;
    a1 = mdl[0][8'hFE];
    push(e0 + 1, 1'b0, "r034_lead");
    for (int i = 0; i < 3; i++) push(e0 + 2 + i, a1[7-i], "r034_pre");
    repeat (4) drive(1'b0, 1'b0);
    rst = 1'b1;
    drive(1'b0, 1'b0);
    check("r034_rst_miso", miso[0], 0);
    check("r034_rst_busy", busy[0], 0);
    rst = 1'b0;
    drive(1'b1, 1'b0);
    check("r034_idle", busy[0], 0);
    read_cur(8'h00, 1, "r034_addr0");
    read_words(8'hFE, 2, "r034_intact");

    // Non-burst instance: trailing word in the same frame is ignored
    sel = 1;
    set_addr(2'b00, 8'h41);
    cmd_frame(2'b01, 8'h5A);
    end_frame();
    mdl[1][8'h41] = 8'h5A;
    set_addr(2'b00, 8'h40);
    cmd_frame(2'b01, 8'h33);
    send_bits(8'hCC, 8);
    end_frame();
    mdl[1][8'h40] = 8'h33;
    read_words(8'h40, 1, "r035_a");
    read_words(8'h41, 1, "r035_b");

    repeat (3) step();
    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_burst_ram_wrapper.md
SPI_BURST_RAM_WRAPPER -- requirements
Module: spi_burst_ram_wrapper

Interface
REQ-001 Parameter DATA_W, default 8, RAM word width and SPI payload width in bits.
REQ-002 Parameter ADDR_W, default 8, address width; ADDR_W <= DATA_W required; MEM_DEPTH = 2**ADDR_W.
REQ-003 Parameter BURST_EN, default 1; 1 = burst mode enabled, 0 = one word per frame.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 SS_n  input  1  slave select, active-low; frame boundary.
REQ-007 MOSI  input  1  serial data in, MSB first, sampled on rising clk.
REQ-008 MISO  output  1  serial data out, MSB first, registered.
REQ-009 busy  output  1  high whenever state is not IDLE.

Function
REQ-010 States SHALL be IDLE, RX_CMD, WRITE, READ_ADD, READ_DATA.
REQ-011 IDLE -> RX_CMD when SS_n sampled 0; bit counter cleared.
REQ-012 RX_CMD SHALL shift 2 command bits then DATA_W payload bits from MOSI, MSB first.
REQ-013 Command codes (first bit, second bit): 00 write address, 01 write data, 10 read address, 11 read data.
REQ-014 00: write-address register <= payload[ADDR_W-1:0] on the cycle the last payload bit is sampled; 10: read-address register likewise.
REQ-015 01: mem[write-address] <= payload on the cycle the last payload bit is sampled.
REQ-016 11: payload bits SHALL be ignored; RAM read of mem[read-address] issued at last bit; MISO drives word MSB from the 2nd rising edge after last bit sampled, one bit per clock, DATA_W bits.
REQ-017 MISO SHALL be 0 whenever no read word is being shifted out.
REQ-018 BURST_EN=1, after 01 with SS_n still low: write-address increments; each further DATA_W MOSI bits (no command prefix) written to the new address; repeats until SS_n high.
REQ-019 BURST_EN=1, after 11 with SS_n still low: read-address increments and next word prefetched; its MSB follows the previous word's LSB with no gap cycle; MOSI ignored.
REQ-020 Burst address increment SHALL wrap MEM_DEPTH-1 -> 0.
REQ-021 Commands 00/10 SHALL never burst; bits after them until SS_n high ignored.
REQ-022 BURST_EN=0: after any command completes, bits ignored until SS_n high; no address increment.
REQ-023 SS_n sampled 1 in any non-IDLE state SHALL return to IDLE next cycle; partial word discarded, no RAM write, MISO 0, busy 0.
REQ-024 Read data without prior read address SHALL use read-address reset value 0.
REQ-025 Write address and read address SHALL be separate registers; neither updates the other.
REQ-026 RAM is single-port; read and write never occur in the same cycle by construction.
REQ-027 New frame requires SS_n high for at least 1 cycle between frames.

Reset
REQ-028 rst=1 at a rising edge SHALL force state IDLE, MISO 0, busy 0, both address registers 0, bit counters 0; overrides SS_n and mid-frame activity.
REQ-029 RAM contents SHALL NOT be cleared by reset.

Verification (DATA_W=8, ADDR_W=8)
REQ-030 Frames 00_0x1F, 01_0x55, 10_0x1F, 11_xx -> MISO 0,1,0,1,0,1,0,1 from 2nd edge after last cmd-frame bit; busy high through frames.
REQ-031 BURST_EN=1: 00_0xFE then 01_0xA1 + words 0xA2, 0xA3 in one frame -> mem[0xFE]=A1, mem[0xFF]=A2, mem[0x00]=A3.
REQ-032 10_0xFE then 11 held 24 extra cycles -> MISO streams A1, A2, A3 contiguous, no gap bits.
REQ-033 01 frame with SS_n high after 5 payload bits -> target word unchanged, busy 0 next cycle, write address unchanged.
REQ-034 rst pulsed mid read stream -> MISO 0 and IDLE at that edge; subsequent 11 frame reads mem[0x00]; RAM contents intact.
REQ-035 BURST_EN=0: 01_0x33 followed by 8 more bits 0xCC in same frame -> only mem[addr]=0x33, mem[addr+1] unchanged.
